// File: rtl/rename_dispatch_wide_pkg.sv
// RV32I opcode/decode types plus the dispatch packet carried from rename to the ROB/RS allocators.
package rename_dispatch_wide_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned ARCH_REG_BITS     = 5;
  localparam int unsigned PKT_PHYS_REG_BITS = 6;
  localparam int unsigned PKT_ROB_IDX_BITS  = 5;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MUL = 2'd1,
    RS_DIV = 2'd2,
    RS_BR  = 2'd3
  } rs_class_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [31:0]              inst;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [ARCH_REG_BITS-1:0] rd;
    logic [ARCH_REG_BITS-1:0] rs1;
    logic [ARCH_REG_BITS-1:0] rs2;
    logic [XLEN-1:0]          imm;
  } decode_info_t;

  typedef struct packed {
    decode_info_t                info;
    rs_class_t                   cls;
    logic [PKT_PHYS_REG_BITS-1:0] pd;
    logic [PKT_PHYS_REG_BITS-1:0] ps1;
    logic                         ps1_valid;
    logic [PKT_PHYS_REG_BITS-1:0] ps2;
    logic                         ps2_valid;
    logic [PKT_ROB_IDX_BITS-1:0]  rob_idx;
    logic                         alloc;
  } dispatch_pkt_t;

  // Sign-extended immediate for each RV32I encoding format; R-type yields zero.
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] inst);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (inst[6:0])
      op_b_imm, op_b_load, op_b_jalr: imm = {{20{inst[31]}}, inst[31:20]};
      op_b_store:                     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      op_b_br:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      op_b_lui, op_b_auipc:           imm = {inst[31:12], 12'h000};
      op_b_jal:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                        imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rename_decode.sv
// Per-slot combinational classifier: reservation-station class, allocation flag and decode fields.
module rename_decode
  import rename_dispatch_wide_pkg::*;
(
  input  logic [31:0]   inst,
  input  logic [31:0]   pc,
  output decode_info_t  info_c,
  output rs_class_t     cls_c,
  output logic          alloc_c
);

  always_comb begin
    info_c        = '0;
    info_c.pc     = pc;
    info_c.inst   = inst;
    info_c.opcode = inst[6:0];
    info_c.funct3 = inst[14:12];
    info_c.funct7 = inst[31:25];
    info_c.rd     = inst[11:7];
    info_c.rs1    = inst[19:15];
    info_c.rs2    = inst[24:20];
    info_c.imm    = decode_imm(inst);

    // funct3 0..3 are the multiplies, 4..7 the divides/remainders
    cls_c = RS_ALU;
    case (inst[6:0])
      op_b_jal, op_b_jalr, op_b_br: cls_c = RS_BR;
      op_b_reg: begin
        if (inst[31:25] == FUNCT7_MULDIV) cls_c = inst[14] ? RS_DIV : RS_MUL;
        else                              cls_c = RS_ALU;
      end
      default: cls_c = RS_ALU;
    endcase

    alloc_c = (inst[6:0] != op_b_br) && (inst[6:0] != op_b_store) && (inst[11:7] != '0);
  end

endmodule

// File: rtl/rename_dispatch_wide.sv
// WIDTH-wide rename/dispatch: in-order prefix selection against resources, intra-group
// bypass and WAW suppression, and a registered valid/ready output stage.
module rename_dispatch_wide
  import rename_dispatch_wide_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned ROB_IDX_BITS  = 5,
  localparam int unsigned CW           = $clog2(WIDTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [WIDTH-1:0]                    iq_valid,
  input  logic [WIDTH-1:0][31:0]              iq_inst,
  input  logic [WIDTH-1:0][31:0]              iq_pc,
  output logic [CW-1:0]                       iq_deq_cnt,
  input  logic [WIDTH-1:0][PHYS_REG_BITS-1:0] fl_pd,
  input  logic [CW-1:0]                       fl_avail,
  output logic [CW-1:0]                       fl_pop_cnt,
  output logic [WIDTH-1:0][4:0]               rat_rs1,
  output logic [WIDTH-1:0][4:0]               rat_rs2,
  input  logic [WIDTH-1:0][PHYS_REG_BITS-1:0] rat_ps1,
  input  logic [WIDTH-1:0][PHYS_REG_BITS-1:0] rat_ps2,
  input  logic [WIDTH-1:0]                    rat_ps1_valid,
  input  logic [WIDTH-1:0]                    rat_ps2_valid,
  output logic [WIDTH-1:0]                    rat_we,
  output logic [WIDTH-1:0][4:0]               rat_rd,
  output logic [WIDTH-1:0][PHYS_REG_BITS-1:0] rat_pd,
  input  logic [CW-1:0]                       rob_free,
  input  logic [ROB_IDX_BITS-1:0]             rob_tail,
  input  logic [3:0][CW-1:0]                  rs_space,
  output logic [WIDTH-1:0]                    disp_valid,
  input  logic                                disp_ready,
  output dispatch_pkt_t [WIDTH-1:0]           disp_pkt
);

  decode_info_t [WIDTH-1:0]                    info;
  rs_class_t                                   cls [WIDTH];
  logic [WIDTH-1:0]                            alloc;
  logic                                        can_load;
  logic [CW-1:0]                               k;
  logic [CW-1:0]                               pop;
  logic [WIDTH-1:0]                            ok;
  logic [WIDTH-1:0][PHYS_REG_BITS-1:0]         pd;
  logic [WIDTH-1:0]                            we;
  dispatch_pkt_t [WIDTH-1:0]                   pkt_d;

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_dec
    rename_decode u_dec (
      .inst    (iq_inst[gi]),
      .pc      (iq_pc[gi]),
      .info_c  (info[gi]),
      .cls_c   (cls[gi]),
      .alloc_c (alloc[gi])
    );
  end

  assign can_load = (disp_valid == '0) || disp_ready;

  // Prefix selection: each slot needs a ROB entry, its share of free regs and RS space.
  always_comb begin : count
    logic [CW-1:0]      n_alloc;
    logic [3:0][CW-1:0] n_cls;
    logic               run;
    n_alloc = '0;
    n_cls   = '0;
    run     = can_load && !flush;
    k       = '0;
    pop     = '0;
    ok      = '0;
    pd      = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      for (int j = 0; j < int'(WIDTH); j++) begin
        if (CW'(j) == n_alloc) pd[i] = fl_pd[j];
      end
      if (alloc[i]) n_alloc = n_alloc + CW'(1);
      n_cls[cls[i]] = n_cls[cls[i]] + CW'(1);
      run = run && iq_valid[i] && (CW'(i + 1) <= rob_free) && (n_alloc <= fl_avail)
            && (n_cls[cls[i]] <= rs_space[cls[i]]);
      ok[i] = run;
      if (run) begin
        k = k + CW'(1);
        if (alloc[i]) pop = pop + CW'(1);
      end
    end
  end

  // Operand bypass from earlier allocating slots (nearest wins) and youngest-writer RAT update.
  always_comb begin : bypass
    pkt_d = '0;
    we    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pkt_d[i].info      = info[i];
      pkt_d[i].cls       = cls[i];
      pkt_d[i].alloc     = alloc[i];
      pkt_d[i].pd        = PKT_PHYS_REG_BITS'(pd[i]);
      pkt_d[i].ps1       = PKT_PHYS_REG_BITS'(rat_ps1[i]);
      pkt_d[i].ps1_valid = rat_ps1_valid[i];
      pkt_d[i].ps2       = PKT_PHYS_REG_BITS'(rat_ps2[i]);
      pkt_d[i].ps2_valid = rat_ps2_valid[i];
      for (int j = 0; j < int'(WIDTH); j++) begin
        if (j < i && alloc[j]) begin
          if (info[j].rd == info[i].rs1) begin
            pkt_d[i].ps1       = PKT_PHYS_REG_BITS'(pd[j]);
            pkt_d[i].ps1_valid = 1'b0;
          end
          if (info[j].rd == info[i].rs2) begin
            pkt_d[i].ps2       = PKT_PHYS_REG_BITS'(pd[j]);
            pkt_d[i].ps2_valid = 1'b0;
          end
        end
      end
      if (info[i].rs1 == '0) begin
        pkt_d[i].ps1       = '0;
        pkt_d[i].ps1_valid = 1'b1;
      end
      if (info[i].rs2 == '0) begin
        pkt_d[i].ps2       = '0;
        pkt_d[i].ps2_valid = 1'b1;
      end
      pkt_d[i].rob_idx = PKT_ROB_IDX_BITS'(rob_tail + ROB_IDX_BITS'(i));
      if (!ok[i]) pkt_d[i] = '0;

      we[i] = alloc[i] && ok[i];
      for (int j = 0; j < int'(WIDTH); j++) begin
        if (j > i && ok[j] && alloc[j] && (info[j].rd == info[i].rd)) we[i] = 1'b0;
      end
    end
  end

  // Handshake outputs are forced to zero while reset is held.
  always_comb begin : drive
    iq_deq_cnt = '0;
    fl_pop_cnt = '0;
    rat_rs1    = '0;
    rat_rs2    = '0;
    rat_we     = '0;
    rat_rd     = '0;
    rat_pd     = '0;
    if (rst) begin
      iq_deq_cnt = k;
      fl_pop_cnt = pop;
      rat_we     = we;
      for (int i = 0; i < int'(WIDTH); i++) begin
        rat_rs1[i] = info[i].rs1;
        rat_rs2[i] = info[i].rs2;
        rat_rd[i]  = info[i].rd;
        rat_pd[i]  = pd[i];
      end
    end
  end

  // Output stage: flush clears, otherwise load the whole group when empty or accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_valid <= '0;
      disp_pkt   <= '0;
    end else if (flush) begin
      disp_valid <= '0;
      disp_pkt   <= '0;
    end else if (can_load) begin
      disp_valid <= ok;
      disp_pkt   <= pkt_d;
    end
  end

endmodule

// File: tb/tb_rename_dispatch_wide.sv
// Directed bench for the 2-wide rename/dispatch stage with hand-computed expectations.
module tb_rename_dispatch_wide;
  import rename_dispatch_wide_pkg::*;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned PRB   = 6;
  localparam int unsigned RIB   = 5;
  localparam int unsigned CW    = 2;

  localparam logic [31:0] I_ADDI_X1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD_X2  = 32'h00108133;  // add  x2,x1,x1
  localparam logic [31:0] I_BEQ     = 32'hFE208EE3;  // beq  x1,x2,-4
  localparam logic [31:0] I_SW      = 32'h0020A423;  // sw   x2,8(x1)
  localparam logic [31:0] I_ADDI_X3 = 32'h00100193;  // addi x3,x0,1
  localparam logic [31:0] I_MUL_X5  = 32'h027302B3;  // mul  x5,x6,x7
  localparam logic [31:0] I_MUL_X8  = 32'h02730433;  // mul  x8,x6,x7
  localparam logic [31:0] I_DIV_X9  = 32'h027344B3;  // div  x9,x6,x7

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          flush;
  logic [WIDTH-1:0]              iq_valid;
  logic [WIDTH-1:0][31:0]        iq_inst;
  logic [WIDTH-1:0][31:0]        iq_pc;
  logic [CW-1:0]                 iq_deq_cnt;
  logic [WIDTH-1:0][PRB-1:0]     fl_pd;
  logic [CW-1:0]                 fl_avail;
  logic [CW-1:0]                 fl_pop_cnt;
  logic [WIDTH-1:0][4:0]         rat_rs1;
  logic [WIDTH-1:0][4:0]         rat_rs2;
  logic [WIDTH-1:0][PRB-1:0]     rat_ps1;
  logic [WIDTH-1:0][PRB-1:0]     rat_ps2;
  logic [WIDTH-1:0]              rat_ps1_valid;
  logic [WIDTH-1:0]              rat_ps2_valid;
  logic [WIDTH-1:0]              rat_we;
  logic [WIDTH-1:0][4:0]         rat_rd;
  logic [WIDTH-1:0][PRB-1:0]     rat_pd;
  logic [CW-1:0]                 rob_free;
  logic [RIB-1:0]                rob_tail;
  logic [3:0][CW-1:0]            rs_space;
  logic [WIDTH-1:0]              disp_valid;
  logic                          disp_ready;
  dispatch_pkt_t [WIDTH-1:0]     disp_pkt;

  int total = 0;
  int bad   = 0;

  rename_dispatch_wide #(.WIDTH(WIDTH), .PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_deq_cnt(iq_deq_cnt),
    .fl_pd(fl_pd), .fl_avail(fl_avail), .fl_pop_cnt(fl_pop_cnt),
    .rat_rs1(rat_rs1), .rat_rs2(rat_rs2), .rat_ps1(rat_ps1), .rat_ps2(rat_ps2),
    .rat_ps1_valid(rat_ps1_valid), .rat_ps2_valid(rat_ps2_valid),
    .rat_we(rat_we), .rat_rd(rat_rd), .rat_pd(rat_pd),
    .rob_free(rob_free), .rob_tail(rob_tail), .rs_space(rs_space),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pkt(disp_pkt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic defaults();
    flush         = 1'b0;
    iq_valid      = 2'b11;
    iq_pc         = {32'h0000_1004, 32'h0000_1000};
    fl_avail      = 2'd2;
    rob_free      = 2'd2;
    rob_tail      = '0;
    rs_space      = {2'd2, 2'd2, 2'd2, 2'd2};
    disp_ready    = 1'b1;
    rat_ps1       = {6'd31, 6'd30};
    rat_ps2       = {6'd41, 6'd40};
    rat_ps1_valid = 2'b11;
    rat_ps2_valid = 2'b11;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    defaults();
    iq_inst = {I_ADD_X2, I_ADDI_X1};
    fl_pd   = {6'd11, 6'd10};
    #2 rst = 1'b0;
    #1;
    check("rst_valid", 64'(disp_valid), 64'd0);
    check("rst_pkt_zero", 64'(disp_pkt == '0), 64'd1);
    check("rst_deq_gated", 64'(iq_deq_cnt), 64'd0);
    check("rst_pop_gated", 64'(fl_pop_cnt), 64'd0);
    check("rst_we_gated", 64'(rat_we), 64'd0);
    tick();
    check("rst_valid_clk", 64'(disp_valid), 64'd0);
    rst = 1'b1;

    // dependent pair: addi x1 feeds add x2
    #1;
    check("t1_deq", 64'(iq_deq_cnt), 64'd2);
    check("t1_pop", 64'(fl_pop_cnt), 64'd2);
    check("t1_we", 64'(rat_we), 64'd3);
    check("t1_rat_pd", 64'(rat_pd), 64'({6'd11, 6'd10}));
    check("t1_rat_rd", 64'(rat_rd), 64'({5'd2, 5'd1}));
    check("t1_rat_rs1", 64'(rat_rs1), 64'({5'd1, 5'd0}));
    tick();
    check("t1_disp_valid", 64'(disp_valid), 64'd3);
    check("t1_s1_ps1", 64'(disp_pkt[1].ps1), 64'd10);
    check("t1_s1_ps1v", 64'(disp_pkt[1].ps1_valid), 64'd0);
    check("t1_s1_ps2", 64'(disp_pkt[1].ps2), 64'd10);
    check("t1_s1_ps2v", 64'(disp_pkt[1].ps2_valid), 64'd0);
    check("t1_s0_ps1_x0", 64'({disp_pkt[0].ps1, disp_pkt[0].ps1_valid}), 64'd1);
    check("t1_s0_imm", 64'(disp_pkt[0].info.imm), 64'd5);
    check("t1_s1_pd", 64'(disp_pkt[1].pd), 64'd11);
    check("t1_rob", 64'({disp_pkt[1].rob_idx, disp_pkt[0].rob_idx}), 64'({5'd1, 5'd0}));
    check("t1_pc", 64'(disp_pkt[1].info.pc), 64'h1004);

    // branch + store: no allocation, RAT pass-through
    iq_inst = {I_SW, I_BEQ};
    #1;
    check("t2_deq", 64'(iq_deq_cnt), 64'd2);
    check("t2_pop", 64'(fl_pop_cnt), 64'd0);
    check("t2_we", 64'(rat_we), 64'd0);
    tick();
    check("t2_cls0", 64'(disp_pkt[0].cls), 64'(RS_BR));
    check("t2_cls1", 64'(disp_pkt[1].cls), 64'(RS_ALU));
    check("t2_alloc", 64'({disp_pkt[1].alloc, disp_pkt[0].alloc}), 64'd0);
    check("t2_br_imm", 64'(disp_pkt[0].info.imm), 64'hFFFF_FFFC);
    check("t2_st_imm", 64'(disp_pkt[1].info.imm), 64'd8);
    check("t2_s0_ps1", 64'({disp_pkt[0].ps1, disp_pkt[0].ps1_valid}), 64'({6'd30, 1'b1}));
    check("t2_s1_ps2", 64'(disp_pkt[1].ps2), 64'd41);

    // WAW: two writers of x3, only the younger updates the RAT
    iq_inst = {I_ADDI_X3, I_ADDI_X3};
    fl_pd   = {6'd21, 6'd20};
    #1;
    check("t3_we", 64'(rat_we), 64'b10);
    check("t3_rat_pd1", 64'(rat_pd[1]), 64'd21);
    check("t3_pop", 64'(fl_pop_cnt), 64'd2);
    tick();
    check("t3_alloc", 64'({disp_pkt[1].alloc, disp_pkt[0].alloc}), 64'b11);
    check("t3_pd", 64'({disp_pkt[1].pd, disp_pkt[0].pd}), 64'({6'd21, 6'd20}));

    // MUL RS has one entry: only slot 0 goes
    iq_inst     = {I_MUL_X8, I_MUL_X5};
    rs_space[1] = 2'd1;
    #1;
    check("t4_deq", 64'(iq_deq_cnt), 64'd1);
    check("t4_pop", 64'(fl_pop_cnt), 64'd1);
    check("t4_we", 64'(rat_we), 64'b01);
    tick();
    check("t4_valid", 64'(disp_valid), 64'b01);
    check("t4_cls", 64'(disp_pkt[0].cls), 64'(RS_MUL));
    iq_valid = 2'b01;
    iq_inst  = {I_ADDI_X3, I_MUL_X8};
    fl_pd    = {6'd23, 6'd22};
    #1;
    check("t4b_deq", 64'(iq_deq_cnt), 64'd1);
    tick();
    check("t4b_rd_pd", 64'({disp_pkt[0].info.rd, disp_pkt[0].pd}), 64'({5'd8, 6'd22}));
    iq_valid    = 2'b11;
    iq_inst     = {I_MUL_X8, I_MUL_X5};
    rs_space[1] = 2'd0;
    #1;
    check("t4c_deq_none", 64'(iq_deq_cnt), 64'd0);
    check("t4c_pop_none", 64'(fl_pop_cnt), 64'd0);
    tick();
    check("t4c_valid_empty", 64'(disp_valid), 64'd0);
    rs_space[1] = 2'd2;

    // ROB index wrap
    iq_inst  = {I_ADDI_X3, I_DIV_X9};
    rob_tail = 5'd31;
    #1;
    check("t5_deq", 64'(iq_deq_cnt), 64'd2);
    tick();
    check("t5_rob", 64'({disp_pkt[1].rob_idx, disp_pkt[0].rob_idx}), 64'({5'd0, 5'd31}));
    check("t5_cls_div", 64'(disp_pkt[0].cls), 64'(RS_DIV));
    rob_tail = '0;

    // resource boundaries
    iq_inst  = {I_ADDI_X3, I_ADDI_X3};
    rob_free = 2'd1;
    #1;
    check("t6_rob1_deq", 64'(iq_deq_cnt), 64'd1);
    tick();
    rob_free = 2'd2;
    fl_avail = 2'd1;
    #1;
    check("t6_fl1_deq", 64'(iq_deq_cnt), 64'd1);
    check("t6_fl1_pop", 64'(fl_pop_cnt), 64'd1);
    tick();
    iq_inst = {I_ADDI_X3, I_BEQ};
    #1;
    check("t6_br_deq", 64'(iq_deq_cnt), 64'd2);
    check("t6_br_pop", 64'(fl_pop_cnt), 64'd1);
    check("t6_br_pd1", 64'(rat_pd[1]), 64'd22);
    tick();
    fl_avail = 2'd2;

    // stall for 3 cycles, then flush
    iq_inst  = {I_ADD_X2, I_ADDI_X1};
    fl_pd    = {6'd11, 6'd10};
    rob_tail = 5'd4;
    tick();
    check("t7_loaded", 64'(disp_valid), 64'd3);
    disp_ready = 1'b0;
    rob_tail   = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t7_stall_deq", 64'(iq_deq_cnt), 64'd0);
      check("t7_stall_pop", 64'(fl_pop_cnt), 64'd0);
      check("t7_stall_we", 64'(rat_we), 64'd0);
      tick();
      check("t7_hold_valid", 64'(disp_valid), 64'd3);
      check("t7_hold_ps1", 64'(disp_pkt[1].ps1), 64'd10);
      check("t7_hold_rob", 64'(disp_pkt[1].rob_idx), 64'd5);
    end
    flush      = 1'b1;
    disp_ready = 1'b1;
    #1;
    check("t7_flush_deq", 64'(iq_deq_cnt), 64'd0);
    tick();
    check("t7_flush_valid", 64'(disp_valid), 64'd0);
    flush = 1'b0;

    // asynchronous reset in the middle of a cycle
    tick();
    check("t8_loaded", 64'(disp_valid), 64'd3);
    #2 rst = 1'b0;
    #1;
    check("t8_async_valid", 64'(disp_valid), 64'd0);
    check("t8_async_pkt", 64'(disp_pkt == '0), 64'd1);
    check("t8_async_deq", 64'(iq_deq_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_dispatch_wide.md
# rename_dispatch_wide

Parametrised, WIDTH-wide rename/dispatch stage between the instruction queue and the ROB/reservation stations. Each cycle it renames an in-order prefix of up to WIDTH instructions against the RAT and free list, resolving intra-group dependencies. It skips allocation for x0 and for branches and stores. The renamed group is held in a registered output stage with a valid/ready handshake toward the ROB/RS allocators.

## Interface
- WIDTH, 2: instructions renamed per cycle (1..4)
- PHYS_REG_BITS, 6: physical register index width
- ROB_IDX_BITS, 5: ROB index width
- CW = $clog2(WIDTH+1): count width (derived, not overridable)

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  squash: clear output stage, dispatch nothing this cycle
- iq_valid  in  WIDTH  slot has an instruction; prefix-contiguous from slot 0
- iq_inst / iq_pc  in  WIDTH×32  instruction word / its PC
- iq_deq_cnt  out  CW  slots consumed this cycle
- fl_pd  in  WIDTH×PHYS_REG_BITS  next WIDTH free-list heads, in order
- fl_avail  in  CW  free entries available, saturated at WIDTH
- fl_pop_cnt  out  CW  entries popped this cycle
- rat_rs1, rat_rs2  out  WIDTH×5  RAT read addresses
- rat_ps1, rat_ps2  in  WIDTH×PHYS_REG_BITS  RAT mappings
- rat_ps1_valid, rat_ps2_valid  in  WIDTH  mapped value ready
- rat_we  out  WIDTH  RAT write enable per slot
- rat_rd  out  WIDTH×5  architectural dest
- rat_pd  out  WIDTH×PHYS_REG_BITS  new mapping
- rob_free  in  CW  ROB free entries, saturated
- rob_tail  in  ROB_IDX_BITS  next ROB index
- rs_space  in  4×CW  free entries per RS class, saturated
- disp_valid  out  WIDTH  output slot valid, prefix mask
- disp_ready  in  1  downstream accepts the whole group
- disp_pkt  out  WIDTH×dispatch_pkt_t  renamed instruction: decode_info, class, pd, ps1/ps2 with valids, rob_idx, alloc flag

## Operation
- Per slot, classification:
  - ALU for op_b_imm, or op_b_reg with funct7 0000000/0100000.
  - MUL for funct7 0000001 with funct3 in mul..mulhu.
  - DIV for funct7 0000001 with funct3 in div..remu.
  - BR for jal/jalr/br.
  - All remaining opcodes go to ALU.
- alloc = (opcode not br and not store) and rd != 0.
- Dispatch count k = largest n ≤ WIDTH for which every slot i < n satisfies all of:
  - iq_valid[i];
  - i+1 ≤ rob_free;
  - allocating slots in 0..i ≤ fl_avail;
  - slots of the same class in 0..i ≤ rs_space[class];
  - the output stage can load.
- The output stage can load when empty, or when disp_ready = 1. flush forces k = 0.
- Outputs for this cycle:
  - iq_deq_cnt = k.
  - fl_pop_cnt = number of allocating slots < k.
- Slot i takes fl_pd[j], where j = number of allocating slots before i.
- Source operands:
  - A source equal to x0 gives ps = 0, valid = 1.
  - A source matching an allocating earlier slot's rd (nearest earlier slot wins) gives that slot's pd, valid = 0.
  - Any other source passes the RAT mapping through.
- rat_we[i] = alloc and i < k and no later allocating slot < k writes the same rd (WAW inside a group: only the youngest writes).
- rob_idx = (rob_tail + i) mod 2^ROB_IDX_BITS; wraps.
- decode_info.pc = iq_pc[i]. Immediates are decoded as in the existing single-wide decode.
- Output stage:
  - Loads all k slots at once; disp_valid = (1<<k) - 1.
  - When k = 0 and the stage is loading, disp_valid becomes 0.
  - Holds its contents while disp_valid != 0 and disp_ready = 0.

## Timing
- Rename is combinational from iq/fl/RAT/ROB/RS inputs. All pop, deq and RAT-write outputs apply at the same posedge.
- disp_pkt is valid 1 cycle after rename.
- All status inputs are sampled the same cycle, not registered. Producers must present current-cycle counts.
- Throughput is WIDTH per cycle when unstalled. A stall (disp_ready = 0 with valid data) produces k = 0 and pops nothing.
- Reset (asynchronous, mid-operation included):
  - disp_valid = 0 and disp_pkt = 0.
  - All combinational outputs become 0 while rst is low, because iq/fl outputs are gated by the reset.
- flush with disp_ready = 1 in the same cycle: flush wins; the stage clears and the data is not accepted.

## Structure
- Add to rv32i_types:
  - rs_class_t enum: RS_ALU=0, RS_MUL=1, RS_DIV=2, RS_BR=3.
  - dispatch_pkt_t struct, parameterised by PHYS_REG_BITS and ROB_IDX_BITS through package localparams.
- Sub-module rename_decode: per-slot combinational classifier (class, alloc, decode_info), instantiated WIDTH times via generate.
- Top level holds the prefix/count logic, the bypass/WAW priority chains and the output register.

## Test plan
- WIDTH=2, `addi x1,x0,5` and `add x2,x1,x1`, fl_pd={10,11}, all resources free:
  - k=2, fl_pop_cnt=2.
  - Slot 1 gets ps1=ps2=10, valid=0.
  - rat_we=2'b11.
  - disp_valid=2'b11 next cycle.
- Slots `beq` and `sw`: fl_pop_cnt=0, rat_we=0, k=2, pd fields unused.
- `addi x3` twice with fl_pd={20,21}:
  - rat_we=2'b10, rat_pd[1]=21.
  - Both slots carry alloc=1 and pop 2.
- Two MUL slots with rs_space[MUL]=1: k=1, iq_deq_cnt=1. Next cycle, with rs_space[MUL]=1, slot 0 dispatches.
- rob_tail=31, k=2: rob_idx={31,0}.
- disp_ready=0 with held data for 3 cycles, then flush:
  - disp_pkt stable while held; k=0 each cycle.
  - After flush, disp_valid=0.
  - Assert rst low mid-group: disp_valid drops asynchronously.
